// File: rtl/lift_pkg.sv
// Shared types and encodings for the SCAN lift controller.
// Imported by the direction selector and the controller top.
package lift_pkg;

    localparam logic [1:0] MOTOR_IDLE = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b11;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } lift_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lift_dir_select.sv
// Summarises the pending vector relative to the current floor:
// requests above, requests below, and a request at this floor.
module lift_dir_select
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 11,
    parameter int FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    curr_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here
);

    // Compare every floor index against the car position.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        here      = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (FLOOR_W'(i) > curr_floor) any_above = 1'b1;
                if (FLOOR_W'(i) < curr_floor) any_below = 1'b1;
                if (FLOOR_W'(i) == curr_floor) here = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_scan_ctrl.sv
// Single-car lift controller: latches hall/car calls and serves
// them in SCAN order with a fixed door dwell at every stop.
module lift_scan_ctrl
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS    = 11,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hall_req_valid,
    input  logic [FLOOR_W-1:0]    hall_req_floor,
    input  logic [NUM_FLOORS-1:0] car_req,
    output logic [FLOOR_W-1:0]    curr_floor,
    output logic [1:0]            motor_signal,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrived
);

    localparam int CW =
        $clog2(imax(TRAVEL_CYCLES, DOOR_CYCLES)) + 1;
    localparam logic [CW-1:0] T_LAST = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR =
        FLOOR_W'(NUM_FLOORS - 1);

    lift_state_t           state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  dir_up_q, dir_up_d;
    logic                  arrived_q;

    logic                  any_above, any_below, here;
    logic [NUM_FLOORS-1:0] cur_oh, up_oh, dn_oh;
    logic [NUM_FLOORS-1:0] hall_oh, req_vec, clr_vec;
    logic                  hit_up, hit_dn, enter_door;

    lift_dir_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_dir (
        .pending    (pend_q),
        .curr_floor (floor_q),
        .any_above  (any_above),
        .any_below  (any_below),
        .here       (here)
    );

    // One-hot views of the car position and the hall call.
    always_comb begin
        cur_oh  = '0;
        hall_oh = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_oh[i]  = (floor_q == FLOOR_W'(i));
            hall_oh[i] = hall_req_valid &&
                         (hall_req_floor == FLOOR_W'(i));
        end
        up_oh  = cur_oh << 1;
        dn_oh  = cur_oh >> 1;
        hit_up = |(pend_q & up_oh);
        hit_dn = |(pend_q & dn_oh);
    end

    // Next state: SCAN sequencing, travel and dwell timing.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        cnt_d      = cnt_q;
        dir_up_d   = dir_up_q;
        clr_vec    = '0;
        enter_door = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (here) begin
                    state_d    = DOOR_OPEN;
                    clr_vec    = cur_oh;
                    enter_door = 1'b1;
                end else if (any_above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP: begin
                if (!any_above || floor_q == TOP_FLOOR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == T_LAST) begin
                    floor_d = floor_q + 1'b1;
                    cnt_d   = '0;
                    if (hit_up) begin
                        state_d    = DOOR_OPEN;
                        clr_vec    = up_oh;
                        enter_door = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (!any_below || floor_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == T_LAST) begin
                    floor_d = floor_q - 1'b1;
                    cnt_d   = '0;
                    if (hit_dn) begin
                        state_d    = DOOR_OPEN;
                        clr_vec    = dn_oh;
                        enter_door = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (cnt_q == D_LAST) begin
                    cnt_d = '0;
                    if (dir_up_q && any_above) begin
                        state_d = MOVE_UP;
                    end else if (!dir_up_q && any_below) begin
                        state_d = MOVE_DOWN;
                    end else if (any_above) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (any_below) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // New calls merge in; a call at an open door is absorbed,
    // and a clear beats a latch on the same edge.
    always_comb begin
        req_vec = car_req | hall_oh;
        if (state_q == DOOR_OPEN) req_vec = req_vec & ~cur_oh;
        pend_d = (pend_q | req_vec) & ~clr_vec;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            arrived_q <= enter_door;
        end
    end

    // Drivers follow the registered state.
    always_comb begin
        motor_signal = MOTOR_IDLE;
        if (state_q == MOVE_UP)   motor_signal = MOTOR_UP;
        if (state_q == MOVE_DOWN) motor_signal = MOTOR_DOWN;
        door_open  = (state_q == DOOR_OPEN);
        curr_floor = floor_q;
        pending    = pend_q;
        arrived    = arrived_q;
    end

endmodule

// File: doc/lift_scan_ctrl.md
Name: lift_scan_ctrl

Overview:
Parametrised next-generation single-car elevator controller. It latches hall and car requests into one pending-floor vector and serves them with SCAN (elevator-algorithm) ordering. It adds a door-dwell phase, configurable travel time and floor count. It sits between the floor/cabin request inputs and the motor/door drivers, and replaces the fixed 11-floor controller.

Parameters:
NUM_FLOORS, 11, number of floors, indexed 0..NUM_FLOORS-1
FLOOR_W, 4, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS
TRAVEL_CYCLES, 2, clock cycles to move one floor (>=1)
DOOR_CYCLES, 4, clock cycles door stays open per stop (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
hall_req_valid  input  1  hall call strobe, sampled each cycle
hall_req_floor  input  FLOOR_W  hall call floor; ignored if >= NUM_FLOORS
car_req  input  NUM_FLOORS  cabin buttons, bit i = floor i, level/pulse, OR'd in
curr_floor  output  FLOOR_W  current floor
motor_signal  output  2  00 idle/stopped, 11 up, 10 down
door_open  output  1  door open indication
pending  output  NUM_FLOORS  registered pending-request vector
arrived  output  1  one-cycle pulse on the cycle door_open rises

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state IDLE, curr_floor=0, motor_signal=00, door_open=0, pending=0, arrived=0, travel/dwell counters=0, dir_up=1. Mid-operation reset aborts travel immediately; no partial floor moves.
- Request latch: at each edge, pending[i] <= 1 if car_req[i], or if hall_req_valid and hall_req_floor==i and i<NUM_FLOORS. 1-cycle latency to pending.
- Absorb rule: a request for curr_floor arriving while in DOOR_OPEN is not latched and does not extend the dwell.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. motor_signal = 11 in MOVE_UP, 10 in MOVE_DOWN, 00 otherwise. door_open=1 only in DOOR_OPEN.
- Helpers (combinational on pending and curr_floor): any_above, any_below, here = pending[curr_floor].
- IDLE:
  - here -> DOOR_OPEN, clearing pending[curr_floor].
  - else any_above -> MOVE_UP; else any_below -> MOVE_DOWN.
  - If both above and below are pending, prefer up.
- MOVE_x: travel counter starts at 0 on entry. When counter==TRAVEL_CYCLES-1, curr_floor steps ±1 and the counter resets.
  - Same edge, if pending[next floor] is set: enter DOOR_OPEN, clear that bit, pulse arrived.
  - Else continue if requests remain ahead; else go IDLE.
- Range: never step above NUM_FLOORS-1 or below 0. A MOVE state with nothing ahead returns to IDLE.
- DOOR_OPEN: lasts exactly DOOR_CYCLES cycles. Then SCAN decision:
  - Keep the last direction (dir_up) if requests remain that way.
  - Else reverse if requests exist the other way.
  - Else go IDLE.
  - here pending at exit (only possible via the IDLE path) re-opens.
- Simultaneous events: a latch and a clear of the same bit in one edge -> clear wins (absorb rule). Latching at other floors is never blocked by state.
- Widths: counters sized $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES))+1. No wrap of curr_floor.

Decomposition:
- Shared package lift_pkg:
  - motor encodings MOTOR_IDLE=2'b00, MOTOR_UP=2'b11, MOTOR_DOWN=2'b10
  - state enum lift_state_t {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN}
- Sub-module lift_dir_select (combinational, parametrised by NUM_FLOORS/FLOOR_W): takes pending and curr_floor, outputs any_above, any_below, here. The top level keeps the FSM, counters and request register.

Test Plan (defaults: TRAVEL_CYCLES=2, DOOR_CYCLES=4):
1. Reset, then hall call floor 3 at edge 0 -> motor_signal=11 after edge 1; curr_floor=1/2/3 after edges 3/5/7; door_open=1 and arrived pulse after edge 7; door_open high 4 cycles; then IDLE, motor 00, pending=0.
2. Moving up from 0 toward 8, car_req floor 5 asserted while curr_floor=2 -> stops at 5 (door 4 cycles), resumes up and stops at 8; pending[5] cleared at the stop at 5.
3. At floor 5 after stops, pending={2,9}, last direction up -> serves 9 first, then reverses (motor 10) to 2.
4. IDLE at floor 4, simultaneous requests for floors 1 and 7 -> motor 11 first (up preference).
5. Hall call floor 15 with NUM_FLOORS=11 -> pending unchanged, motor stays 00. Request for floor 4 while doors open at 4 -> not latched, dwell still 4 cycles.
6. rst asserted mid-travel (curr_floor=3, motor 11) -> next edge curr_floor=0, motor 00, door_open 0, pending=0. Requests held during rst are not latched.
